// File: rtl/car_motion_ctrl.sv
// Sprite motion controller: each frame it advances a bouncing position and writes x0/y0
// into the shared sprite-core slot, otherwise passing CPU traffic through. Option: CAR_ANIM_EN.
module car_motion_ctrl #(
    parameter int unsigned H_LIMIT  = 608,
    parameter int unsigned V_LIMIT  = 448,
    parameter int unsigned ANIM_DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        move_en,
    input  logic [3:0]  speed_x,
    input  logic [3:0]  speed_y,
    input  logic        cpu_cs,
    input  logic        cpu_write,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic        cpu_ready,
    output logic        cs,
    output logic        write,
    output logic [13:0] addr,
    output logic [31:0] wr_data,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        busy
);
    localparam logic [10:0] X_MAX  = 11'(H_LIMIT);
    localparam logic [10:0] Y_MAX  = 11'(V_LIMIT);
    localparam logic [13:0] ADDR_X = 14'h2001;
    localparam logic [13:0] ADDR_Y = 14'h2002;

    typedef enum logic [2:0] {IDLE, CALC, WR_X, WR_Y, WR_CTRL} state_t;

    state_t      state, state_nxt;
    logic        dir_x, dir_y;  // 0 = increasing, 1 = decreasing
    logic [11:0] step_x, step_y;
    logic        cpu_wr_x, cpu_wr_y;

    // Returns {new_dir, new_pos}; bounces off 0 and the limit.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic [3:0] speed,
                                              input logic dir, input logic [10:0] limit);
        logic signed [11:0] nxt;
        nxt = dir ? $signed({1'b0, pos}) - $signed({8'b0, speed})
                  : $signed({1'b0, pos}) + $signed({8'b0, speed});
        if (nxt < 0)
            return {1'b0, 11'd0};
        if (nxt > $signed({1'b0, limit}))
            return {1'b1, limit};
        return {dir, nxt[10:0]};
    endfunction

    function automatic logic [10:0] clamp_axis(input logic [10:0] v, input logic [10:0] limit);
        return (v > limit) ? limit : v;
    endfunction

    assign step_x   = step_axis(pos_x, speed_x, dir_x, X_MAX);
    assign step_y   = step_axis(pos_y, speed_y, dir_y, Y_MAX);
    assign cpu_wr_x = cpu_ready && cpu_cs && cpu_write && (cpu_addr == ADDR_X);
    assign cpu_wr_y = cpu_ready && cpu_cs && cpu_write && (cpu_addr == ADDR_Y);
    assign busy     = (state != IDLE);

`ifdef CAR_ANIM_EN
    localparam int unsigned     FC_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(ANIM_DIV - 1);
    localparam logic [13:0]     ADDR_CTRL = 14'h2003;

    logic [FC_W-1:0] frame_cnt;
    logic [1:0]      anim_idx;
    logic            anim_due;

    // The step is counted during CALC so WR_CTRL already carries the advanced index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            anim_idx  <= '0;
            anim_due  <= 1'b0;
        end else if (state == CALC) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                anim_idx  <= anim_idx + 2'd1;
                anim_due  <= 1'b1;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
                anim_due  <= 1'b0;
            end
        end
    end
`else
    if (ANIM_DIV == 0) begin : g_anim_div_unused
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pos_x <= '0;
            pos_y <= '0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else begin
            state <= state_nxt;
            // A CPU write of a coordinate replaces that axis' motion update entirely.
            if (cpu_wr_x)
                pos_x <= clamp_axis(cpu_wr_data[10:0], X_MAX);
            else if (state == CALC)
                {dir_x, pos_x} <= step_x;
            if (cpu_wr_y)
                pos_y <= clamp_axis(cpu_wr_data[10:0], Y_MAX);
            else if (state == CALC)
                {dir_y, pos_y} <= step_y;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        cs        = 1'b0;
        write     = 1'b0;
        addr      = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (frame_start && move_en)
                    state_nxt = CALC;
            end
            CALC: begin
                cpu_ready = 1'b1;
                state_nxt = WR_X;
            end
            WR_X: begin
                cs        = 1'b1;
                write     = 1'b1;
                addr      = ADDR_X;
                wr_data   = {21'b0, pos_x};
                state_nxt = WR_Y;
            end
            WR_Y: begin
                cs        = 1'b1;
                write     = 1'b1;
                addr      = ADDR_Y;
                wr_data   = {21'b0, pos_y};
`ifdef CAR_ANIM_EN
                state_nxt = anim_due ? WR_CTRL : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef CAR_ANIM_EN
            WR_CTRL: begin
                cs        = 1'b1;
                write     = 1'b1;
                addr      = ADDR_CTRL;
                wr_data   = {27'b0, 3'b001, anim_idx};
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        if (cpu_ready && cpu_cs) begin
            cs      = 1'b1;
            write   = cpu_write;
            addr    = cpu_addr;
            wr_data = cpu_wr_data;
        end
        if (reset) begin
            cs      = 1'b0;
            write   = 1'b0;
            addr    = '0;
            wr_data = '0;
        end
    end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// Self-checking bench for car_motion_ctrl: transaction-queue reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours CAR_ANIM_EN if defined.
module tb_car_motion_ctrl;
    localparam int H_LIMIT  = 608;
    localparam int V_LIMIT  = 448;
    localparam int ANIM_DIV = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        move_en = 1'b0;
    logic [3:0]  speed_x = '0;
    logic [3:0]  speed_y = '0;
    logic        cpu_cs = 1'b0;
    logic        cpu_write = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic        cpu_ready, cs, write, busy;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [10:0] pos_x, pos_y;

    car_motion_ctrl #(.H_LIMIT(H_LIMIT), .V_LIMIT(V_LIMIT), .ANIM_DIV(ANIM_DIV)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .move_en(move_en),
        .speed_x(speed_x), .speed_y(speed_y), .cpu_cs(cpu_cs), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_ready(cpu_ready), .cs(cs),
        .write(write), .addr(addr), .wr_data(wr_data), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference model: pending slot operations, one per upcoming busy cycle.
    typedef struct packed { logic calc; logic [13:0] a; logic [31:0] d; } op_t;
    op_t sq[$];
    int  m_x = 0, m_y = 0, m_dx = 1, m_dy = 1, m_bursts = 0, m_anim = 0;

    task automatic advance(inout int p, inout int d, input int spd, input int lim);
        int n;
        n = p + d * spd;
        if (n < 0) begin p = 0; d = 1; end
        else if (n > lim) begin p = lim; d = -1; end
        else p = n;
    endtask

    task automatic model_step();
        bit idle_now, calc_now, ready_now, wx, wy;
        int v;
        if (reset) begin
            m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_bursts = 0; m_anim = 0;
            sq.delete();
            return;
        end
        idle_now  = (sq.size() == 0);
        calc_now  = !idle_now && sq[0].calc;
        ready_now = idle_now || calc_now;
        wx = ready_now && cpu_cs && cpu_write && cpu_addr == 14'h2001;
        wy = ready_now && cpu_cs && cpu_write && cpu_addr == 14'h2002;
        if (!idle_now) void'(sq.pop_front());
        if (calc_now) begin
            if (!wx) advance(m_x, m_dx, int'(speed_x), H_LIMIT);
            if (!wy) advance(m_y, m_dy, int'(speed_y), V_LIMIT);
        end
        v = int'(cpu_wr_data[10:0]);
        if (wx) m_x = (v > H_LIMIT) ? H_LIMIT : v;
        if (wy) m_y = (v > V_LIMIT) ? V_LIMIT : v;
        if (calc_now) begin
            sq.push_back('{1'b0, 14'h2001, 32'(m_x)});
            sq.push_back('{1'b0, 14'h2002, 32'(m_y)});
`ifdef CAR_ANIM_EN
            m_bursts++;
            if (m_bursts % ANIM_DIV == 0) begin
                m_anim = (m_anim + 1) % 4;
                sq.push_back('{1'b0, 14'h2003, 32'(4 + m_anim)});
            end
`endif
        end
        if (idle_now && frame_start && move_en) sq.push_back('{1'b1, 14'h0, 32'h0});
    endtask

    task automatic compare_cycle();
        logic [71:0] act, expv;
        logic r, b, c, w;
        logic [13:0] a;
        logic [31:0] d;
        act = {cpu_ready, busy, cs, write, addr, wr_data, pos_x, pos_y};
        if (reset) begin
            expv = {1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 11'd0, 11'd0};
        end else begin
            b = (sq.size() != 0);
            if (b && !sq[0].calc) begin
                r = 1'b0; c = 1'b1; w = 1'b1; a = sq[0].a; d = sq[0].d;
            end else begin
                r = 1'b1;
                if (cpu_cs) begin c = 1'b1; w = cpu_write; a = cpu_addr; d = cpu_wr_data; end
                else begin c = 1'b0; w = 1'b0; a = '0; d = '0; end
            end
            expv = {r, b, c, w, a, d, 11'(m_x), 11'(m_y)};
        end
        check("cycle", act, expv);
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); compare_cycle(); end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus changes 2 time units after each rising edge; peeks happen 4 units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [13:0] cap_addr [8];
    logic [31:0] cap_data [8];
    int          cap_n, cap_busy;

    task automatic burst(input int cycles);
        cap_n = 0;
        cap_busy = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #2;
            if (busy) cap_busy++;
            if (cs && write && !cpu_ready && cap_n < 8) begin
                cap_addr[cap_n] = addr;
                cap_data[cap_n] = wr_data;
                cap_n++;
            end
            tick();
        end
    endtask

    task automatic cpu_wr(input logic [13:0] a, input logic [31:0] d);
        int waited;
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wr_data = d;
        waited = 0;
        while (!cpu_ready && waited < 8) begin tick(); waited++; end
        if (!cpu_ready) check("cpu_wr_ready_timeout", 1'b0, 1'b1);
        tick();
        cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    endtask

    function automatic logic [13:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 14'h2001;
            1: return 14'h2002;
            2: return 14'h2003;
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        int low, seen, n_y, n_rdy, ctrl_cnt, total_wr;
        logic [31:0] last_ctrl;
        bit pending, accepted;

        tick();
        #2;
        check("reset_state", {cpu_ready, busy, cs, write, addr, wr_data, pos_x, pos_y},
              {1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 11'd0, 11'd0});
        tick();
        reset = 1'b0;

        // Basic burst from reset: x += 3, y += 2.
        move_en = 1'b1; speed_x = 4'd3; speed_y = 4'd2;
        burst(5);
        check("a_nwrites", cap_n, 2);
        check("a_wr0", {cap_addr[0], cap_data[0]}, {14'h2001, 32'd3});
        check("a_wr1", {cap_addr[1], cap_data[1]}, {14'h2002, 32'd2});
        check("a_busy_cycles", cap_busy, 3);
        check("a_pos", {pos_x, pos_y}, {11'd3, 11'd2});
        check("a_model_x", m_x, 3);

        // Right-edge clamp and bounce back.
        reset_dut();
        speed_x = 4'd4; speed_y = 4'd0;
        cpu_wr(14'h2001, 32'd606);
        burst(5);
        check("b_clamp_x", {cap_addr[0], cap_data[0]}, {14'h2001, 32'd608});
        check("b_model_x", m_x, 608);
        burst(5);
        check("b_bounce_x", {cap_addr[0], cap_data[0]}, {14'h2001, 32'd604});

        // CPU write held across the write phase.
        reset_dut();
        speed_x = 4'd1; speed_y = 4'd1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_addr = 14'h0123; cpu_wr_data = 32'hDEADBEEF;
        low = 0; seen = 0;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (cpu_ready) begin
                check("c_passthru", {cs, write, addr, wr_data}, {1'b1, 1'b1, 14'h0123, 32'hDEADBEEF});
                seen = 1;
                break;
            end
            low++;
            tick();
        end
        tick();
        cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        check("c_ready_low_cycles", low, 2);
        check("c_ready_seen", seen, 1);

        // CPU y write beyond the limit: slot sees raw data, position clamps.
        reset_dut();
        cpu_cs = 1'b1; cpu_write = 1'b1; cpu_addr = 14'h2002; cpu_wr_data = 32'd700;
        #2;
        check("d_slot_raw", {cs, write, addr, wr_data}, {1'b1, 1'b1, 14'h2002, 32'd700});
        tick();
        cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        #2;
        check("d_pos_y", pos_y, 11'd448);
        check("d_model_y", m_y, 448);
        tick();

        // Reset during WR_X suppresses the rest of the burst.
        reset_dut();
        speed_x = 4'd5; speed_y = 4'd5;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        #1;
        check("e_wr_x_active", {cs, addr}, {1'b1, 14'h2001});
        reset = 1'b1;
        #1;
        check("e_slot_quiet", {cs, write, addr, wr_data, busy}, '0);
        tick();
        reset = 1'b0;
        n_y = 0; n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (cs && addr == 14'h2002) n_y++;
            if (cpu_ready) n_rdy++;
            tick();
        end
        check("e_no_y_write", n_y, 0);
        check("e_ready_after", n_rdy, 6);
        check("e_pos_zero", {pos_x, pos_y}, {11'd0, 11'd0});

        // Animation control writes.
        reset_dut();
        speed_x = 4'd1; speed_y = 4'd1;
        ctrl_cnt = 0; total_wr = 0; last_ctrl = '0;
`ifdef CAR_ANIM_EN
        for (int b = 1; b <= 32; b++) begin
            burst(6);
            for (int k = 0; k < cap_n; k++)
                if (cap_addr[k] == 14'h2003) begin ctrl_cnt++; last_ctrl = cap_data[k]; end
            if (b == 8) check("f_ctrl_after8", {ctrl_cnt, last_ctrl}, {32'd1, 32'h05});
        end
        check("f_ctrl_after32", {ctrl_cnt, last_ctrl}, {32'd4, 32'h04});
`else
        for (int b = 1; b <= 8; b++) begin
            burst(5);
            total_wr += cap_n;
            for (int k = 0; k < cap_n; k++)
                if (cap_addr[k] == 14'h2003) ctrl_cnt++;
        end
        check("f_no_ctrl", {ctrl_cnt, total_wr}, {32'd0, 32'd16});
`endif

        // Randomized traffic against the model.
        pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                cpu_cs = 1'b0; cpu_write = 1'b0; frame_start = 1'b0;
                reset = 1'b1; tick(); reset = 1'b0;
                pending = 1'b0;
                continue;
            end
            if (!pending) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_cs = 1'b1;
                    cpu_write = ($urandom_range(0, 4) != 0);
                    cpu_addr = pick_addr();
                    cpu_wr_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
                end else begin
                    cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
                end
            end
            frame_start = ($urandom_range(0, 3) == 0);
            move_en = ($urandom_range(0, 7) != 0);
            speed_x = 4'($urandom_range(0, 15));
            speed_y = 4'($urandom_range(0, 15));
            #2;
            accepted = cpu_ready;
            tick();
            pending = cpu_cs && !accepted;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/car_motion_ctrl.md
CAR_MOTION_CTRL -- requirements
Module: car_motion_ctrl

Interface
REQ-001 SHALL have parameter H_LIMIT, default 608, meaning the maximum x0 (640 minus the 32-pixel sprite width).
REQ-002 SHALL have parameter V_LIMIT, default 448, meaning the maximum y0 (480 minus the 32-pixel sprite height).
REQ-003 SHALL have parameter ANIM_DIV, default 8, meaning the number of frames per animation step.
REQ-004 SHALL have port: clk  in  1  clock; all logic is rising-edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: frame_start  in  1  one-cycle pulse at the start of vertical blank.
REQ-007 SHALL have port: move_en  in  1  enables autonomous motion.
REQ-008 SHALL have port: speed_x, speed_y  in  4 each  unsigned pixels per frame.
REQ-009 SHALL have port: cpu_cs, cpu_write  in  1 each  CPU slot request.
REQ-010 SHALL have port: cpu_addr  in  14  CPU slot address.
REQ-011 SHALL have port: cpu_wr_data  in  32  CPU write data.
REQ-012 SHALL have port: cpu_ready  out  1  CPU request accepted this cycle.
REQ-013 SHALL have port: cs, write  out  1 each  sprite-core slot strobes.
REQ-014 SHALL have port: addr  out  14  sprite-core slot address.
REQ-015 SHALL have port: wr_data  out  32  sprite-core slot data.
REQ-016 SHALL have port: pos_x, pos_y  out  11 each  current tracked position.
REQ-017 SHALL have port: busy  out  1  high when the FSM is not in IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, WR_X, WR_Y and WR_CTRL.
REQ-019 SHALL transition IDLE->CALC on frame_start&move_en, then CALC->WR_X->WR_Y->(WR_CTRL if anim step due)->IDLE, one cycle per state.
REQ-020 SHALL issue in WR_X: cs=write=1, addr=0x2001, wr_data={21'b0,pos_x}.
REQ-021 SHALL issue in WR_Y: cs=write=1, addr=0x2002, wr_data={21'b0,pos_y}.
REQ-022 SHALL issue in WR_CTRL: cs=write=1, addr=0x2003, wr_data={27'b0,3'b001,anim_idx[1:0]}.
REQ-023 SHALL, in CALC, compute next x = pos_x +/- speed_x according to dir_x, using 12-bit signed intermediate arithmetic.
REQ-024 SHALL, if the next x is below 0, set pos_x=0 and dir_x=+; if above H_LIMIT, set pos_x=H_LIMIT and dir_x=-; otherwise take the next x; y SHALL follow identically using V_LIMIT.
REQ-025 SHALL treat speed 0 as leaving the position and direction unchanged.
REQ-026 SHALL assert cpu_ready in IDLE and CALC and deassert it in the WR_* states; the CPU holds its request until ready.
REQ-027 SHALL, when cpu_ready=1, pass cpu_cs, cpu_write, cpu_addr and cpu_wr_data combinationally to cs, write, addr and wr_data.
REQ-028 SHALL, when cpu_ready=1, drive cs=write=0 and addr=wr_data=0 while no CPU request is present.
REQ-029 SHALL, on an accepted CPU write to 0x2001 or 0x2002, also load pos_x or pos_y from wr_data[10:0], clamped to its limit.
REQ-030 SHALL give an accepted CPU position write priority over a CALC update of the same coordinate in the same cycle.
REQ-031 SHALL, when frame_start and a CPU request coincide in IDLE, serve the CPU that cycle and still enter CALC.
REQ-032 SHALL ignore frame_start outside IDLE.
REQ-033 SHALL, when move_en=0, stay in IDLE and pass all CPU traffic through.

Reset
REQ-034 SHALL, on reset, asynchronously force state=IDLE, pos_x=pos_y=0, dir_x=dir_y=+, anim_idx=0, frame_cnt=0 and cs=write=addr=wr_data=0.
REQ-035 SHALL, on reset asserted mid-burst, suppress any remaining writes; after release the FSM resumes from IDLE with cpu_ready=1.

Configuration
REQ-036 SHALL, with CAR_ANIM_EN defined, count frames in frame_cnt; each ANIM_DIV-th burst increments anim_idx (wrapping 3->0) and includes WR_CTRL.
REQ-037 SHALL, without CAR_ANIM_EN, omit frame_cnt, anim_idx and WR_CTRL, so every burst ends WR_Y->IDLE.

Verification
REQ-038 SHALL verify: reset, move_en=1, speed_x=3, speed_y=2, one frame_start -> writes 0x2001/3 then 0x2002/2, busy for 3 cycles.
REQ-039 SHALL verify: pos_x=606, speed_x=4, dir +, then frame_start -> x0 write is 608 and the next frame writes 604.
REQ-040 SHALL verify: CPU write held during WR_X -> cpu_ready=0 for 2 cycles; the write appears on the slot unchanged in the first IDLE cycle.
REQ-041 SHALL verify: CPU writes 0x2002/700 -> pos_y=448 and the slot receives 700 unchanged.
REQ-042 SHALL verify: with CAR_ANIM_EN and ANIM_DIV=8, 8 frames -> exactly one WR_CTRL, data 0x05; 32 frames -> anim_idx wraps to 0 (data 0x04).
REQ-043 SHALL verify: reset pulsed in WR_X -> no 0x2002 write occurs, and pos_x=pos_y=0.
